// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_DROP
  } if_state_e;

  localparam logic [5:0]  OP_J             = 6'd2;
  localparam logic [5:0]  OP_JAL           = 6'd3;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic is_jump(input logic [31:0] instr);
    return (instr[31:26] == OP_J) || (instr[31:26] == OP_JAL);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats enable; data only moves with a valid instruction.
module if_id_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [31:0] ir_i,
  input  logic [31:0] pc4_i,
  output logic        valid_o,
  output logic [31:0] ir_o,
  output logic [31:0] pc4_o
);

  logic        valid_q;
  logic [31:0] ir_q;
  logic [31:0] pc4_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid_q <= 1'b0;
      ir_q    <= '0;
      pc4_q   <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        ir_q  <= ir_i;
        pc4_q <= pc4_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign ir_o    = ir_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, I-cache request FSM, hold buffer and IF/ID register.
// Optional J/JAL predecode redirect enabled by IF_JUMP_PREDECODE_EN.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ICACHE_ren,
  output logic        ICACHE_wen,
  output logic [29:0] ICACHE_addr,
  output logic [31:0] ICACHE_wdata,
  input  logic        ICACHE_stall,
  input  logic [31:0] ICACHE_rdata,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_ir,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  ir_opcode,
  output logic [5:0]  ir_func
);

  // state  | meaning
  // S_REQ  | request at req_addr outstanding
  // S_HOLD | fetched word parked while decode is stalled
  // S_DROP | wrong-path access still completing, result discarded
  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [29:0] req_q, req_d;
  logic [31:0] hold_ir_q, hold_ir_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;

  logic        done;
  logic [31:0] redir_tgt;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_pc4;
  logic [31:0] fetch_next;
  logic        ld_valid;
  logic [31:0] ld_ir;
  logic [31:0] ld_pc4;

  assign ICACHE_ren   = !rst && (state_q != S_HOLD);
  assign ICACHE_wen   = 1'b0;
  assign ICACHE_wdata = '0;
  assign ICACHE_addr  = req_q;

  assign done      = ICACHE_ren && !ICACHE_stall;
  assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign pc_plus4  = pc_q + 32'd4;
  assign fetch_pc4 = {req_q, 2'b00} + 32'd4;

`ifdef IF_JUMP_PREDECODE_EN
  assign fetch_next = is_jump(ICACHE_rdata)
                    ? {fetch_pc4[31:28], ICACHE_rdata[25:0], 2'b00}
                    : pc_plus4;
`else
  assign fetch_next = pc_plus4;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_q      <= RESET_PC[31:2];
      hold_ir_q  <= '0;
      hold_pc4_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      hold_ir_q  <= hold_ir_d;
      hold_pc4_q <= hold_pc4_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    hold_ir_d  = hold_ir_q;
    hold_pc4_d = hold_pc4_q;
    ld_valid   = 1'b0;
    ld_ir      = ICACHE_rdata;
    ld_pc4     = fetch_pc4;
    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redir_tgt;
          if (done) req_d   = redir_tgt[31:2];
          else      state_d = S_DROP;
        end else if (done) begin
          pc_d  = fetch_next;
          req_d = fetch_next[31:2];
          if (id_stall) begin
            hold_ir_d  = ICACHE_rdata;
            hold_pc4_d = fetch_pc4;
            state_d    = S_HOLD;
          end else begin
            ld_valid = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          req_d   = redir_tgt[31:2];
          state_d = S_REQ;
        end else if (!id_stall) begin
          ld_valid = 1'b1;
          ld_ir    = hold_ir_q;
          ld_pc4   = hold_pc4_q;
          state_d  = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_d = redir_tgt;
        if (done) begin
          req_d   = pc_d[31:2];
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .en_i    (!id_stall),
    .flush_i (redirect_valid),
    .valid_i (ld_valid),
    .ir_i    (ld_ir),
    .pc4_i   (ld_pc4),
    .valid_o (if_id_valid),
    .ir_o    (if_id_ir),
    .pc4_o   (if_id_pc4)
  );

  assign ir_opcode = if_id_ir[31:26];
  assign ir_func   = if_id_ir[5:0];

endmodule
